result_formatter: RTL and testbench

Converts the calculator core's signed two's-complement result into the sign-magnitude form consumed by the 7-segment output driver. It takes the absolute value, a negative flag, and an error flag, and optionally converts the magnitude to packed BCD with a sequential double-dabble engine so that decimal digits are displayed. It sits between the ALU/result register (upstream) and the shift-register display driver (downstream), with a valid/ready handshake on both sides.

---
 rtl/result_formatter.sv | 146 ++++++++++++++
 tb/tb_result_formatter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_formatter.sv
// Signed result -> sign-magnitude formatter for the 7-segment driver, with valid/ready on both sides.
// Define RESULT_FORMATTER_DECIMAL_EN to build the double-dabble BCD converter and decimal overflow check.
module result_formatter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic                  i_error,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_error,
  output logic                  o_data_is_neg,
  output logic                  o_valid,
  input  logic                  i_ready
);

  typedef enum logic [1:0] {IDLE, ABS, CONVERT, OUTPUT} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  error_in_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  error_q;
  logic                  neg_q;
  logic                  valid_q;

  logic                  neg_d;
  logic [DATA_WIDTH-1:0] mag_d;

  // The most negative input has no positive counterpart; its magnitude wraps to itself.
  assign neg_d = result_q[DATA_WIDTH-1];
  assign mag_d = neg_d ? (~result_q + DATA_WIDTH'(1)) : result_q;

`ifdef RESULT_FORMATTER_DECIMAL_EN
  localparam int NDIG = DATA_WIDTH / 4;
  localparam int CW   = $clog2(DATA_WIDTH);

  function automatic logic [DATA_WIDTH-1:0] max_decimal();
    logic [DATA_WIDTH-1:0] p;
    p = DATA_WIDTH'(1);
    for (int k = 0; k < NDIG; k++) p = p * DATA_WIDTH'(10);
    return p - DATA_WIDTH'(1);
  endfunction

  localparam logic [DATA_WIDTH-1:0] MAX_DEC = max_decimal();

  logic [DATA_WIDTH-1:0] bin_q, bcd_q;
  logic [DATA_WIDTH-1:0] bin_d, bcd_d, bcd_adj;
  logic [CW-1:0]         iter_q;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                           : bcd_q[4*gi +: 4];
  end

  assign bcd_d = {bcd_adj[DATA_WIDTH-2:0], bin_q[DATA_WIDTH-1]};
  assign bin_d = {bin_q[DATA_WIDTH-2:0], 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      result_q   <= '0;
      error_in_q <= 1'b0;
      data_q     <= '0;
      error_q    <= 1'b0;
      neg_q      <= 1'b0;
      valid_q    <= 1'b0;
`ifdef RESULT_FORMATTER_DECIMAL_EN
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            result_q   <= i_result;
            error_in_q <= i_error;
            state_q    <= ABS;
          end
        end
        ABS: begin
          if (error_in_q) begin
            data_q  <= '0;
            error_q <= 1'b1;
            neg_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= OUTPUT;
          end else begin
`ifdef RESULT_FORMATTER_DECIMAL_EN
            if (mag_d > MAX_DEC) begin
              data_q  <= '0;
              error_q <= 1'b1;
              neg_q   <= 1'b0;
              valid_q <= 1'b1;
              state_q <= OUTPUT;
            end else begin
              error_q <= 1'b0;
              neg_q   <= neg_d && (mag_d != '0);
              bin_q   <= mag_d;
              bcd_q   <= '0;
              iter_q  <= '0;
              state_q <= CONVERT;
            end
`else
            data_q  <= mag_d;
            error_q <= 1'b0;
            neg_q   <= neg_d && (mag_d != '0);
            valid_q <= 1'b1;
            state_q <= OUTPUT;
`endif
          end
        end
`ifdef RESULT_FORMATTER_DECIMAL_EN
        CONVERT: begin
          bin_q  <= bin_d;
          bcd_q  <= bcd_d;
          iter_q <= iter_q + CW'(1);
          if (iter_q == CW'(DATA_WIDTH - 1)) begin
            data_q  <= bcd_d;
            valid_q <= 1'b1;
            state_q <= OUTPUT;
          end
        end
`endif
        OUTPUT: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready       = rst_n && (state_q == IDLE);
  assign o_data        = data_q;
  assign o_error       = error_q;
  assign o_data_is_neg = neg_q;
  assign o_valid       = valid_q;

endmodule

// File: tb/tb_result_formatter.sv
// Scoreboard bench for result_formatter: random and directed stimulus, decoupled output monitor.
module tb_result_formatter;
  localparam int DW = 16;
`ifdef RESULT_FORMATTER_DECIMAL_EN
  localparam int RST_DLY = 4;
`else
  localparam int RST_DLY = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] i_result = '0;
  logic          i_error = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_error;
  logic          o_data_is_neg;
  logic          o_valid;
  logic          i_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    logic          neg;
    int            lat;
    int            acc;
    int            hold;
  } exp_t;

  exp_t sb_q[$];

  result_formatter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .i_result(i_result), .i_error(i_error), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_error(o_error), .o_data_is_neg(o_data_is_neg),
    .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the signed value and decimal digits.
  function automatic exp_t model(input logic [DW-1:0] r, input logic e);
    exp_t x;
    int v, mag;
    x.data = '0; x.err = 1'b0; x.neg = 1'b0; x.lat = 1; x.acc = 0; x.hold = 0;
    if (e) begin
      x.err = 1'b1;
      return x;
    end
    v = int'($signed(r));
    mag = (v < 0) ? -v : v;
`ifdef RESULT_FORMATTER_DECIMAL_EN
    if (mag > 9999) begin
      x.err = 1'b1;
      return x;
    end
    x.neg = (v < 0);
    for (int k = 0; k < DW / 4; k++) x.data[4*k +: 4] = 4'((mag / (10 ** k)) % 10);
    x.lat = DW + 1;
`else
    x.data = DW'(mag);
    x.neg = (v < 0);
`endif
    return x;
  endfunction

  // Called at a negedge; returns at a negedge after the transaction is accepted.
  task automatic send(input logic [DW-1:0] r, input logic e, input int hold);
    exp_t x;
    int w;
    i_result = r;
    i_error  = e;
    i_valid  = 1'b1;
    w = 0;
    while (!o_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!o_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      i_valid = 1'b0;
      return;
    end
    x = model(r, e);
    x.acc  = cyc + 1;
    x.hold = hold;
    sb_q.push_back(x);
    $display("send   result=%h error=%0d -> exp data=%h err=%0d neg=%0d lat=%0d",
             r, e, x.data, x.err, x.neg, x.lat);
    @(negedge clk);
    i_valid  = 1'b0;
    i_result = DW'($urandom);
    i_error  = 1'($urandom);
  endtask

  // Monitor / consumer
  initial begin
    logic prev_v;
    exp_t cur;
    int   hold;
    prev_v = 1'b0;
    hold   = 0;
    cur    = model('0, 1'b0);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v  = 1'b0;
        i_ready = 1'b0;
        continue;
      end
      if (o_valid) begin
        check("o_ready_low_while_valid", 32'(o_ready), 32'd0);
        if (!prev_v) begin
          if (sb_q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
            hold = 0;
          end else begin
            cur = sb_q.pop_front();
            hold = cur.hold;
            check("data", 32'(o_data), 32'(cur.data));
            check("error", 32'(o_error), 32'(cur.err));
            check("neg", 32'(o_data_is_neg), 32'(cur.neg));
            check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
            $display("output data=%h err=%0d neg=%0d latency=%0d hold=%0d",
                     o_data, o_error, o_data_is_neg, cyc - cur.acc, hold);
          end
        end else begin
          check("data_stable", 32'(o_data), 32'(cur.data));
          check("error_stable", 32'(o_error), 32'(cur.err));
          check("neg_stable", 32'(o_data_is_neg), 32'(cur.neg));
        end
        if (hold == 0) i_ready = 1'b1;
        else begin
          hold--;
          i_ready = 1'b0;
        end
      end else begin
        if (prev_v) begin
          check("valid_drop_only_on_handshake", 32'(i_ready), 32'd1);
          check("o_ready_after_handshake", 32'(o_ready), 32'd1);
        end
        i_ready = 1'b0;
      end
      prev_v = o_valid;
    end
  end

  // Stimulus
  initial begin
    int w;
    logic [DW-1:0] r;
    repeat (3) @(negedge clk);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_data", 32'(o_data), 32'd0);
    check("rst_o_error", 32'(o_error), 32'd0);
    check("rst_o_neg", 32'(o_data_is_neg), 32'd0);
    check("rst_o_ready", 32'(o_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("o_ready_after_reset", 32'(o_ready), 32'd1);

    send(16'h04D2, 1'b0, 0);
    send(16'hFF85, 1'b0, 1);
    send(16'h0000, 1'b0, 0);
    send(16'h2710, 1'b0, 2);
    send(16'h8000, 1'b0, 0);
    send(16'hFFFF, 1'b0, 0);
    send(16'h04D2, 1'b1, 0);
    send(16'h270F, 1'b0, 5);
    send(16'hD8F1, 1'b0, 5);
    send(16'h0001, 1'b0, 0);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 2))
        0: r = DW'($urandom);
        1: r = DW'($urandom_range(0, 12000));
        default: r = DW'(-$urandom_range(0, 12000));
      endcase
      send(r, ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
    end

    w = 0;
    while ((sb_q.size() != 0 || o_valid) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("drain_before_reset_test", 32'(sb_q.size()), 32'd0);

    // Abort an in-flight conversion with reset: nothing must come out.
    i_result = 16'h04D2;
    i_error  = 1'b0;
    i_valid  = 1'b1;
    w = 0;
    while (!o_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    i_valid = 1'b0;
    repeat (RST_DLY) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_o_ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    check("midrst_o_valid", 32'(o_valid), 32'd0);
    check("midrst_o_data", 32'(o_data), 32'd0);
    check("midrst_o_error", 32'(o_error), 32'd0);
    check("midrst_o_neg", 32'(o_data_is_neg), 32'd0);
    rst_n = 1'b1;
    $display("reset  mid-operation applied and released");
    @(negedge clk);
    check("o_ready_after_midrst", 32'(o_ready), 32'd1);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (o_valid) check("valid_after_abort", 32'(o_valid), 32'd0);
    end

    send(16'h0315, 1'b0, 0);
    w = 0;
    while ((sb_q.size() != 0 || o_valid) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("final_drain", 32'(sb_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
